// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DUTY_W     = 7;
  localparam int DUTY_SCALE = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: 7 quotient bits, one per cycle, done pulses with quot.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W+DUTY_W-1:0]  num,
  input  logic [CNT_W-1:0]         den,
  output logic                     busy,
  output logic [DUTY_W-1:0]        quot,
  output logic                     done
);

  localparam int NW     = CNT_W + DUTY_W;
  localparam int STEP_W = $clog2(DUTY_W);

  logic [NW-1:0]     rem;
  logic [NW-1:0]     dsh;
  logic [DUTY_W-1:0] q_acc;
  logic [STEP_W-1:0] step;
  logic              take;
  logic [NW-1:0]     rem_sub;

  // The quotient never exceeds 100, so the divisor starts shifted by DUTY_W-1.
  assign take    = (rem >= dsh);
  assign rem_sub = rem - dsh;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      dsh   <= '0;
      q_acc <= '0;
      step  <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem   <= num;
        dsh   <= NW'(den) << (DUTY_W - 1);
        q_acc <= '0;
        step  <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        if (take) rem <= rem_sub;
        dsh   <= dsh >> 1;
        q_acc <= {q_acc[DUTY_W-2:0], take};
        step  <= step + STEP_W'(1);
        if (step == STEP_W'(DUTY_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= {q_acc[DUTY_W-2:0], take};
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and derives duty in percent.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              meas_valid,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid,
  output logic              no_signal
);

  localparam int NW = CNT_W + DUTY_W;

  logic [1:0]       sync_ff;
  logic             hist;
  logic             rise;
  logic             fall;
  state_e           state_q;
  state_e           state_d;
  logic             arm;
  logic             capture;
  logic             timeout;
  logic [CNT_W-1:0] per_run;
  logic [CNT_W-1:0] high_run;
  logic             div_start;
  logic             div_busy;
  logic [NW-1:0]    div_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      hist    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], pwm_in};
      hist    <= sync_ff[1];
    end
  end

  assign rise = sync_ff[1] & ~hist;
  assign fall = ~sync_ff[1] & hist;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Timeout wins over a coincident rise; the next rise re-arms from IDLE.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    capture = 1'b0;
    timeout = (state_q != IDLE) && (per_run == CNT_W'(TIMEOUT));
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          arm     = 1'b1;
        end
      end
      HIGH: begin
        if (timeout)   state_d = IDLE;
        else if (fall) state_d = LOW;
      end
      LOW: begin
        if (timeout) state_d = IDLE;
        else if (rise) begin
          state_d = HIGH;
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // high_run stops on the fall edge so an ideal H-cycle pulse reads exactly H.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_run    <= '0;
      high_run   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        high_cnt   <= high_run;
        period_cnt <= per_run;
        no_signal  <= 1'b0;
      end
      if (timeout) no_signal <= 1'b1;
      if (arm || capture) begin
        per_run  <= CNT_W'(1);
        high_run <= CNT_W'(1);
      end else if (!timeout) begin
        if (state_q == HIGH) begin
          per_run <= per_run + CNT_W'(1);
          if (!fall) high_run <= high_run + CNT_W'(1);
        end else if (state_q == LOW) begin
          per_run <= per_run + CNT_W'(1);
        end
      end
    end
  end

  assign div_start = meas_valid & ~div_busy;
  assign div_num   = NW'(high_cnt) * NW'(DUTY_SCALE);

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (period_cnt),
    .busy  (div_busy),
    .quot  (duty_pct),
    .done  (duty_valid)
  );

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expectations, a negedge monitor checks them.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic [6:0]       duty_pct;
  logic             duty_valid;
  logic             no_signal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = -100;

  int mq_h[$];
  int mq_p[$];
  int dq[$];
  int tq[$];

  typedef struct {
    int h;
    int l;
    int n;
    int duty;
  } vec_t;

  vec_t vecs[4] = '{'{25, 75, 3, 25}, '{1, 2, 6, 33}, '{7, 13, 4, 35}, '{1, 1, 20, 50}};

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .duty_pct   (duty_pct),
    .duty_valid (duty_valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations on every output pulse; models divider occupancy for duty timing.
  always @(negedge clk) begin
    if (rst) begin
      last_start = -100;
      tq.delete();
    end else begin
      if (meas_valid) begin
        if (mq_h.size() == 0) begin
          chk("meas_unexpected", 1, 0);
        end else begin
          chk("meas_high", int'(high_cnt), mq_h.pop_front());
          chk("meas_period", int'(period_cnt), mq_p.pop_front());
          chk("meas_no_signal", int'(no_signal), 0);
        end
        if (cyc - last_start >= 8) begin
          last_start = cyc;
          tq.push_back(cyc + 8);
        end
      end
      if (duty_valid) begin
        if (dq.size() == 0) chk("duty_unexpected", 1, 0);
        else chk("duty_pct", int'(duty_pct), dq.pop_front());
        if (tq.size() == 0) chk("duty_no_start", 1, 0);
        else chk("duty_latency", cyc, tq.pop_front());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic drive_wave(int h, int l, int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(l);
    end
  endtask

  task automatic check_drained(string name);
    chk({name, "_meas_left"}, mq_h.size(), 0);
    chk({name, "_duty_left"}, dq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    chk("rst_high_cnt", int'(high_cnt), 0);
    chk("rst_period_cnt", int'(period_cnt), 0);
    chk("rst_duty_pct", int'(duty_pct), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_duty_valid", int'(duty_valid), 0);
    chk("rst_no_signal", int'(no_signal), 1);
    rst = 1'b0;

    // Directed waveforms: first rise arms, each later rise yields one measurement
    foreach (vecs[v]) begin
      int p;
      int stride;
      do_reset(2);
      tick(5);
      p = vecs[v].h + vecs[v].l;
      stride = (p >= 8) ? 1 : (8 + p - 1) / p;
      for (int i = 0; i < vecs[v].n - 1; i++) begin
        mq_h.push_back(vecs[v].h);
        mq_p.push_back(p);
        if (i % stride == 0) dq.push_back(vecs[v].duty);
      end
      drive_wave(vecs[v].h, vecs[v].l, vecs[v].n);
      tick(30);
      check_drained($sformatf("wave%0d", v));
    end

    // Stuck-high input after two valid periods
    begin
      int w;
      do_reset(2);
      tick(5);
      for (int i = 0; i < 2; i++) begin
        mq_h.push_back(25);
        mq_p.push_back(100);
        dq.push_back(25);
      end
      drive_wave(25, 75, 2);
      pwm_in = 1'b1;
      w = 0;
      while (!no_signal && w < 400) begin
        tick(1);
        w++;
      end
      chk("timeout_latency", w, 203);
      tick(10);
      chk("timeout_no_signal", int'(no_signal), 1);
      chk("timeout_hold_high", int'(high_cnt), 25);
      chk("timeout_hold_period", int'(period_cnt), 100);
      chk("timeout_hold_duty", int'(duty_pct), 25);
      check_drained("stuck");
    end

    // Reset during a HIGH phase discards the partial period
    do_reset(2);
    tick(5);
    pwm_in = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    pwm_in = 1'b0;
    chk("midrst_no_signal", int'(no_signal), 1);
    chk("midrst_high_cnt", int'(high_cnt), 0);
    tick(75);
    for (int i = 0; i < 2; i++) begin
      mq_h.push_back(25);
      mq_p.push_back(100);
      dq.push_back(25);
    end
    drive_wave(25, 75, 3);
    tick(30);
    check_drained("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
